// File: rtl/submdl_cmdseq_if.sv
// Command/datapath bundle for submdl_cmdseq: request levels and handshake in, grant and strobes out.
// The sequencer uses the slave modport; the command side uses master.
interface submdl_cmdseq_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
);
    logic             i_CEN;
    logic [NCH-1:0]   i_RDREQ;
    logic [NCH-1:0]   i_WRREQ;
    logic             i_FLAGIN;
    logic             i_PAGEEND;
    logic             i_ERR;
    logic [NCH-1:0]   o_GRANT;
    logic             o_BUSY;
    logic             o_SETUP;
    logic             o_RDSTRB;
    logic             o_WRSTRB;
    logic             o_DONE;
    logic             o_ERRFLAG;
    logic [CNT_W-1:0] o_BEATCNT;
    logic [2:0]       o_STATE;

    modport master (
        output i_CEN, i_RDREQ, i_WRREQ, i_FLAGIN, i_PAGEEND, i_ERR,
        input  o_GRANT, o_BUSY, o_SETUP, o_RDSTRB, o_WRSTRB, o_DONE,
               o_ERRFLAG, o_BEATCNT, o_STATE
    );

    modport slave (
        input  i_CEN, i_RDREQ, i_WRREQ, i_FLAGIN, i_PAGEEND, i_ERR,
        output o_GRANT, o_BUSY, o_SETUP, o_RDSTRB, o_WRSTRB, o_DONE,
               o_ERRFLAG, o_BEATCNT, o_STATE
    );
endinterface

// File: rtl/submdl_cmdseq.sv
// Bubble-access command sequencer: round-robin grant over NCH channels, setup/ready/transfer FSM.
// Optional ready timeout is built when CMDSEQ_TIMEOUT_EN is defined.
module submdl_cmdseq #(
    parameter int NCH   = 4,
    parameter int CNT_W = 8,
    parameter int TMO_W = 4
) (
    input  logic             i_EMUCLK,
    input  logic             i_RST,
    submdl_cmdseq_if.slave   bus
);
    localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CNT_W-1:0] BEAT_MAX = '1;
    localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NCH - 1);

    if (NCH < 1 || TMO_W < 1) begin : g_param_chk
        $error("submdl_cmdseq: NCH and TMO_W must be at least 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b000,
        ST_SETUP   = 3'b001,
        ST_WAITRDY = 3'b010,
        ST_RDXFER  = 3'b011,
        ST_WRXFER  = 3'b100,
        ST_FINISH  = 3'b101,
        ST_ERROR   = 3'b111
    } state_t;

    state_t           state_q, state_d;
    logic [NCH-1:0]   grant_q, grant_d;
    logic             dir_wr_q, dir_wr_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             busy_q, busy_d;
    logic             setup_q, setup_d;
    logic             done_q, done_d;
    logic             errflag_q, errflag_d;
`ifdef CMDSEQ_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    logic [NCH-1:0]   req_any;
    logic             req_live;
    logic             win_found;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W-1:0] cand;
    logic             beat;

    assign req_any  = bus.i_RDREQ | bus.i_WRREQ;
    assign req_live = |(grant_q & req_any);
    assign beat     = bus.i_FLAGIN;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int k = 1; k <= NCH; k++) begin
            cand = PTR_W'((int'(ptr_q) + k) % NCH);
            if (!win_found && req_any[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        dir_wr_d = dir_wr_q;
        beat_d   = beat_q;
        ptr_d    = ptr_q;
`ifdef CMDSEQ_TIMEOUT_EN
        tmo_d    = tmo_q;
`endif
        if (bus.i_CEN) begin
            case (state_q)
                ST_IDLE: begin
                    if (!bus.i_ERR && win_found) begin
                        grant_d  = NCH'(1) << win_idx;
                        dir_wr_d = bus.i_WRREQ[win_idx];
                        beat_d   = '0;
                        ptr_d    = win_idx;
                        state_d  = (bus.i_RDREQ[win_idx] && bus.i_WRREQ[win_idx])
                                   ? ST_ERROR : ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (bus.i_ERR) begin
                        state_d = ST_ERROR;
                    end else if (!req_live) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end else begin
                        state_d = ST_WAITRDY;
`ifdef CMDSEQ_TIMEOUT_EN
                        tmo_d   = '0;
`endif
                    end
                end
                ST_WAITRDY: begin
                    if (bus.i_ERR) begin
                        state_d = ST_ERROR;
                    end else if (!req_live) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end else if (bus.i_FLAGIN) begin
                        state_d = dir_wr_q ? ST_WRXFER : ST_RDXFER;
                    end else begin
`ifdef CMDSEQ_TIMEOUT_EN
                        tmo_d = tmo_q + 1'b1;
                        if (tmo_q == TMO_LAST) state_d = ST_ERROR;
`endif
                    end
                end
                ST_RDXFER, ST_WRXFER: begin
                    // A strobed beat is always counted, even on the abort cycle.
                    if (beat && beat_q != BEAT_MAX) beat_d = beat_q + 1'b1;
                    if (bus.i_ERR) begin
                        state_d = ST_ERROR;
                    end else if (!req_live) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end else if (beat && bus.i_PAGEEND) begin
                        state_d = ST_FINISH;
                    end else if (beat && beat_q == BEAT_MAX) begin
                        state_d = ST_ERROR;
                    end
                end
                ST_FINISH: begin
                    if (bus.i_ERR) begin
                        state_d = ST_ERROR;
                    end else if (!req_live) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end
                end
                ST_ERROR: begin
                    if (!bus.i_ERR && !req_live) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            endcase
        end
    end

    // Status flags are decoded from the next state so they stay aligned with o_STATE.
    always_comb begin
        busy_d    = (state_d != ST_IDLE);
        setup_d   = (state_d == ST_SETUP);
        done_d    = (state_d == ST_FINISH);
        errflag_d = (state_d == ST_ERROR);
    end

    always_ff @(posedge i_EMUCLK or posedge i_RST) begin
        if (i_RST) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            dir_wr_q  <= 1'b0;
            beat_q    <= '0;
            ptr_q     <= PTR_RST;
            busy_q    <= 1'b0;
            setup_q   <= 1'b0;
            done_q    <= 1'b0;
            errflag_q <= 1'b0;
`ifdef CMDSEQ_TIMEOUT_EN
            tmo_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            dir_wr_q  <= dir_wr_d;
            beat_q    <= beat_d;
            ptr_q     <= ptr_d;
            busy_q    <= busy_d;
            setup_q   <= setup_d;
            done_q    <= done_d;
            errflag_q <= errflag_d;
`ifdef CMDSEQ_TIMEOUT_EN
            tmo_q     <= tmo_d;
`endif
        end
    end

    assign bus.o_GRANT   = grant_q;
    assign bus.o_BUSY    = busy_q;
    assign bus.o_SETUP   = setup_q;
    assign bus.o_DONE    = done_q;
    assign bus.o_ERRFLAG = errflag_q;
    assign bus.o_BEATCNT = beat_q;
    assign bus.o_STATE   = state_q;
    assign bus.o_RDSTRB  = (state_q == ST_RDXFER) & bus.i_FLAGIN & bus.i_CEN;
    assign bus.o_WRSTRB  = (state_q == ST_WRXFER) & bus.i_FLAGIN & bus.i_CEN;
endmodule

// File: tb/tb_submdl_cmdseq.sv
// Directed bench for submdl_cmdseq (NCH=4, CNT_W=8, TMO_W=4); honours CMDSEQ_TIMEOUT_EN.
module tb_submdl_cmdseq;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   nstrb;

    always #5 clk = ~clk;

    submdl_cmdseq_if #(.NCH(4), .CNT_W(8)) bus ();

    submdl_cmdseq #(.NCH(4), .CNT_W(8), .TMO_W(4)) dut (
        .i_EMUCLK (clk),
        .i_RST    (rst),
        .bus      (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_RDREQ   = '0;
        bus.i_WRREQ   = '0;
        bus.i_FLAGIN  = 1'b0;
        bus.i_PAGEEND = 1'b0;
        bus.i_ERR     = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        bus.i_CEN = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // From SETUP: ready, one beat with PAGEEND, land in FINISH.
    task automatic one_beat_access(input logic wr, input string tag);
        step();
        bus.i_FLAGIN = 1'b1;
        step();
        bus.i_PAGEEND = 1'b1;
        #1;
        chk({tag, "_strobe"}, {30'd0, bus.o_WRSTRB, bus.o_RDSTRB}, wr ? 32'd2 : 32'd1);
        step();
        bus.i_FLAGIN  = 1'b0;
        bus.i_PAGEEND = 1'b0;
        chk({tag, "_done"}, bus.o_DONE, 1);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        bus.i_CEN = 1'b0;
        bus.i_RDREQ = 4'b0010;
        step();
        chk("rst_state", bus.o_STATE, 0);
        chk("rst_grant", bus.o_GRANT, 0);
        chk("rst_busy", bus.o_BUSY, 0);
        chk("rst_beatcnt", bus.o_BEATCNT, 0);
        do_reset();

        // Single read access on channel 1.
        bus.i_CEN = 1'b0;
        bus.i_RDREQ = 4'b0010;
        step();
        chk("cen_hold", bus.o_STATE, 0);
        bus.i_CEN = 1'b1;
        step();
        chk("rd_setup_state", bus.o_STATE, 1);
        chk("rd_grant", bus.o_GRANT, 4'b0010);
        chk("rd_setup_flag", bus.o_SETUP, 1);
        step();
        chk("rd_waitrdy", bus.o_STATE, 2);
        chk("rd_setup_low", bus.o_SETUP, 0);
        step();
        step();
        chk("rd_still_wait", bus.o_STATE, 2);
        bus.i_FLAGIN = 1'b1;
        #1;
        chk("rd_wait_nostrb", bus.o_RDSTRB, 0);
        step();
        chk("rd_xfer_state", bus.o_STATE, 3);
        nstrb = 0;
        for (int i = 0; i < 5; i++) begin
            bus.i_PAGEEND = (i == 4);
            #1;
            if (bus.o_RDSTRB === 1'b1) nstrb++;
            step();
        end
        chk("rd_strb_count", nstrb, 5);
        chk("rd_finish_state", bus.o_STATE, 5);
        chk("rd_done", bus.o_DONE, 1);
        chk("rd_beatcnt", bus.o_BEATCNT, 5);
        chk("rd_finish_grant", bus.o_GRANT, 4'b0010);
        idle_inputs();
        step();
        chk("rd_back_idle", bus.o_STATE, 0);
        chk("rd_grant_clr", bus.o_GRANT, 0);
        chk("rd_beat_kept", bus.o_BEATCNT, 5);

        // System error in IDLE blocks arbitration.
        bus.i_ERR = 1'b1;
        bus.i_RDREQ = 4'b0001;
        step();
        chk("idle_err_block", bus.o_STATE, 0);
        idle_inputs();

        // Round robin between RD ch0 and WR ch3.
        do_reset();
        bus.i_RDREQ = 4'b0001;
        bus.i_WRREQ = 4'b1000;
        step();
        chk("rr_first", bus.o_GRANT, 4'b0001);
        one_beat_access(1'b0, "rr_a");
        bus.i_RDREQ = 4'b0000;
        step();
        chk("rr_a_idle", bus.o_STATE, 0);
        bus.i_RDREQ = 4'b0001;
        step();
        chk("rr_second", bus.o_GRANT, 4'b1000);
        one_beat_access(1'b1, "rr_b");
        bus.i_WRREQ = 4'b0000;
        step();
        chk("rr_b_idle", bus.o_STATE, 0);
        bus.i_WRREQ = 4'b1000;
        step();
        chk("rr_third", bus.o_GRANT, 4'b0001);
        idle_inputs();
        step();
        chk("rr_abort_idle", bus.o_STATE, 0);

        // Read and write together on the winner.
        bus.i_RDREQ = 4'b0010;
        bus.i_WRREQ = 4'b0010;
        step();
        chk("rdwr_error", bus.o_STATE, 7);
        chk("rdwr_errflag", bus.o_ERRFLAG, 1);
        step();
        chk("rdwr_error_hold", bus.o_STATE, 7);
        idle_inputs();
        step();
        chk("rdwr_exit", bus.o_STATE, 0);
        chk("rdwr_errflag_clr", bus.o_ERRFLAG, 0);

        // Beat counter overrun in WRXFER.
        bus.i_WRREQ = 4'b0001;
        step();
        step();
        bus.i_FLAGIN = 1'b1;
        step();
        chk("ovr_wrxfer", bus.o_STATE, 4);
        for (int i = 0; i < 255; i++) step();
        chk("ovr_cnt_255", bus.o_BEATCNT, 255);
        chk("ovr_still_xfer", bus.o_STATE, 4);
        step();
        chk("ovr_error", bus.o_STATE, 7);
        chk("ovr_cnt_sat", bus.o_BEATCNT, 255);
        idle_inputs();
        step();
        chk("ovr_exit", bus.o_STATE, 0);

        // i_ERR pulse mid-WRXFER; ERROR holds while the request stays up.
        bus.i_WRREQ = 4'b0001;
        step();
        step();
        bus.i_FLAGIN = 1'b1;
        step();
        step();
        step();
        bus.i_ERR = 1'b1;
        step();
        chk("errpulse_error", bus.o_STATE, 7);
        bus.i_ERR = 1'b0;
        bus.i_FLAGIN = 1'b0;
        step();
        chk("errpulse_hold", bus.o_STATE, 7);
        bus.i_WRREQ = 4'b0000;
        step();
        chk("errpulse_exit", bus.o_STATE, 0);

        // Abort after two read beats.
        bus.i_RDREQ = 4'b0100;
        step();
        step();
        bus.i_FLAGIN = 1'b1;
        step();
        step();
        step();
        chk("abort_no_done_mid", bus.o_DONE, 0);
        bus.i_FLAGIN = 1'b0;
        bus.i_RDREQ = 4'b0000;
        step();
        chk("abort_idle", bus.o_STATE, 0);
        chk("abort_no_done", bus.o_DONE, 0);
        chk("abort_beatcnt", bus.o_BEATCNT, 2);

        // Reset asserted mid-transfer kills the strobe at once.
        bus.i_RDREQ = 4'b0100;
        step();
        step();
        bus.i_FLAGIN = 1'b1;
        step();
        #1;
        chk("mid_rst_strobe_before", bus.o_RDSTRB, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_state", bus.o_STATE, 0);
        chk("mid_rst_strobe", bus.o_RDSTRB, 0);
        chk("mid_rst_grant", bus.o_GRANT, 0);
        do_reset();

        // Ready never arrives.
        bus.i_RDREQ = 4'b0001;
        step();
        step();
        for (int i = 0; i < 14; i++) step();
        chk("tmo_wait14", bus.o_STATE, 2);
        step();
`ifdef CMDSEQ_TIMEOUT_EN
        chk("tmo_error", bus.o_STATE, 7);
`else
        chk("tmo_no_timeout", bus.o_STATE, 2);
`endif
        idle_inputs();
        step();
        chk("tmo_exit", bus.o_STATE, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
